// File: rtl/f_pc_unit_pkg.sv
// Shared pipeline definitions: branch-compare and jump encodings, the fetch FSM
// state encoding and the default boot address.
package f_pc_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // s_D_cmp encodings; any other value never takes the branch
  localparam logic [1:0] BEQ_CMP = 2'b00;
  localparam logic [1:0] BNE_CMP = 2'b01;

  // D_jump encodings; 2'b11 is treated as no jump
  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_JR   = 2'b10;

  typedef enum logic [1:0] {
    StBoot = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10
  } pc_state_e;

  // Sequential fetch address; wraps modulo 2^32
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/f_pc_unit_npc.sv
// F_NPC: purely combinational branch/jump target generation and next-PC priority
// selection (jr > j/jal > taken branch > sequential).
module f_pc_unit_npc
  import f_pc_unit_pkg::*;
(
  input  logic [31:0] f_pc_i,
  input  logic [31:0] d_pc_i,
  input  logic        d_equal_i,
  input  logic [1:0]  s_d_cmp_i,
  input  logic        d_is_branch_i,
  input  logic [1:0]  d_jump_i,
  input  logic [15:0] d_imm16_i,
  input  logic [25:0] d_imm26_i,
  input  logic [31:0] d_rdata1_i,
  output logic [31:0] npc_o,
  output logic        taken_o,
  output logic        jump_o
);

  logic        is_j;
  logic        is_jr;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign is_j      = (d_jump_i == JUMP_J);
  assign is_jr     = (d_jump_i == JUMP_JR);
  assign jump_o    = is_j | is_jr;
  assign taken_o   = d_is_branch_i &
                     (((s_d_cmp_i == BEQ_CMP) & d_equal_i) |
                      ((s_d_cmp_i == BNE_CMP) & ~d_equal_i));
  assign br_target = pc_plus4(d_pc_i) + {{14{d_imm16_i[15]}}, d_imm16_i, 2'b00};
  assign j_target  = {d_pc_i[31:28], d_imm26_i, 2'b00};

  // Priority select of the next fetch address
  always_comb begin
    npc_o = pc_plus4(f_pc_i);
    if (is_jr) begin
      npc_o = d_rdata1_i;
    end else if (is_j) begin
      npc_o = j_target;
    end else if (taken_o) begin
      npc_o = br_target;
    end
  end

endmodule

// File: rtl/f_pc_unit.sv
// Fetch PC unit: BOOT/RUN/HOLD sequencing, the PC register and a redirect counter.
// Optional macro PC_ALIGN_CHECK_EN adds a registered F_pc_misalign flag.
module f_pc_unit
  import f_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [31:0]      D_PC,
  input  logic             D_equal,
  input  logic [1:0]       s_D_cmp,
  input  logic             D_is_branch,
  input  logic [1:0]       D_jump,
  input  logic [15:0]      D_imm16,
  input  logic [25:0]      D_imm26,
  input  logic [31:0]      D_Rdata1,
  output logic [31:0]      F_PC,
  output logic             F_redirect,
  output logic [CNT_W-1:0] F_redirect_cnt
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             F_pc_misalign
`endif
);

  pc_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      npc;
  logic             taken;
  logic             jump_any;
  logic             load_npc;

  f_pc_unit_npc u_npc (
    .f_pc_i        (pc_q),
    .d_pc_i        (D_PC),
    .d_equal_i     (D_equal),
    .s_d_cmp_i     (s_D_cmp),
    .d_is_branch_i (D_is_branch),
    .d_jump_i      (D_jump),
    .d_imm16_i     (D_imm16),
    .d_imm26_i     (D_imm26),
    .d_rdata1_i    (D_Rdata1),
    .npc_o         (npc),
    .taken_o       (taken),
    .jump_o        (jump_any)
  );

  // State, PC and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: any state moves to RUN when enabled, otherwise parks in HOLD
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = en ? StRun : StHold;
      StRun:   state_d = en ? StRun : StHold;
      StHold:  state_d = en ? StRun : StHold;
      default: state_d = StBoot;
    endcase
  end

  // Outputs and datapath next values; NPC loads only from an enabled RUN cycle
  always_comb begin
    load_npc   = (state_q == StRun) & en;
    F_redirect = load_npc & (taken | jump_any);
    pc_d       = load_npc ? npc : pc_q;
    cnt_d      = cnt_q + CNT_W'(F_redirect);
  end

  assign F_PC           = pc_q;
  assign F_redirect_cnt = cnt_q;

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Misalign flag tracks the alignment of the most recently loaded NPC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  // Flag follows each NPC load; the PC itself is loaded unmodified
  always_comb begin
    misalign_d = load_npc ? (npc[1:0] != 2'b00) : misalign_q;
  end

  assign F_pc_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_f_pc_unit.sv
// Bench for f_pc_unit: table of directed D-stage vectors plus hand-written
// reset, stall, counter-wrap and (with PC_ALIGN_CHECK_EN) alignment sequences.
module tb_f_pc_unit;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             en;
  logic [31:0]      D_PC;
  logic             D_equal;
  logic [1:0]       s_D_cmp;
  logic             D_is_branch;
  logic [1:0]       D_jump;
  logic [15:0]      D_imm16;
  logic [25:0]      D_imm26;
  logic [31:0]      D_Rdata1;
  logic [31:0]      F_PC;
  logic             F_redirect;
  logic [CNT_W-1:0] F_redirect_cnt;
`ifdef PC_ALIGN_CHECK_EN
  logic             F_pc_misalign;
`endif

  f_pc_unit #(
    .RESET_PC (32'h0000_3000),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .en             (en),
    .D_PC           (D_PC),
    .D_equal        (D_equal),
    .s_D_cmp        (s_D_cmp),
    .D_is_branch    (D_is_branch),
    .D_jump         (D_jump),
    .D_imm16        (D_imm16),
    .D_imm26        (D_imm26),
    .D_Rdata1       (D_Rdata1)
    ,
    .F_PC           (F_PC),
    .F_redirect     (F_redirect),
    .F_redirect_cnt (F_redirect_cnt)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .F_pc_misalign  (F_pc_misalign)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] d_pc;
    logic        d_equal;
    logic [1:0]  s_cmp;
    logic        is_br;
    logic [1:0]  jump;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rdata1;
    logic        exp_red;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic eq, input logic [1:0] cmp,
                       input logic br, input logic [1:0] jmp, input logic [15:0] i16,
                       input logic [25:0] i26, input logic [31:0] rd1);
    D_PC = pc; D_equal = eq; s_D_cmp = cmp; D_is_branch = br;
    D_jump = jmp; D_imm16 = i16; D_imm26 = i26; D_Rdata1 = rd1;
  endtask

  initial begin
    // d_pc, eq, cmp, br, jump, imm16, imm26, rdata1, exp_red, exp_pc, exp_cnt
    vecs[0]  = '{32'h3004, 1, 2'b00, 1, 2'b00, 16'hFFFF, 26'h0, 32'h0, 1, 32'h3004, 1};
    vecs[1]  = '{32'h3004, 1, 2'b01, 1, 2'b00, 16'h0010, 26'h0, 32'h0, 0, 32'h3008, 1};
    vecs[2]  = '{32'h3008, 1, 2'b00, 1, 2'b10, 16'h0010, 26'h0, 32'h3100, 1, 32'h3100, 2};
    vecs[3]  = '{32'h3100, 1, 2'b00, 1, 2'b01, 16'h0010, 26'h0C80, 32'h0, 1, 32'h3200, 3};
    vecs[4]  = '{32'h3200, 0, 2'b01, 1, 2'b00, 16'h0010, 26'h0, 32'h0, 1, 32'h3244, 4};
    vecs[5]  = '{32'h3244, 0, 2'b00, 1, 2'b00, 16'h0010, 26'h0, 32'h0, 0, 32'h3248, 4};
    vecs[6]  = '{32'h3248, 1, 2'b10, 1, 2'b00, 16'h0010, 26'h0, 32'h0, 0, 32'h324C, 4};
    vecs[7]  = '{32'h0, 0, 2'b00, 0, 2'b11, 16'h0, 26'h0, 32'h0, 0, 32'h3250, 4};
    vecs[8]  = '{32'h3250, 1, 2'b00, 0, 2'b00, 16'h0010, 26'h0, 32'h0, 0, 32'h3254, 4};
    vecs[9]  = '{32'h0, 0, 2'b00, 0, 2'b10, 16'h0, 26'h0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 5};
    vecs[10] = '{32'h0, 0, 2'b00, 0, 2'b00, 16'h0, 26'h0, 32'h0, 0, 32'h0000_0000, 5};
    vecs[11] = '{32'h0, 1, 2'b00, 1, 2'b00, 16'h8000, 26'h0, 32'h0, 1, 32'hFFFE_0004, 6};
    vecs[12] = '{32'hFFFE_0004, 0, 2'b00, 0, 2'b01, 16'h0, 26'h3FF_FFFF, 32'h0, 1,
                 32'hFFFF_FFFC, 7};
    vecs[13] = '{32'h0, 0, 2'b00, 0, 2'b10, 16'h0, 26'h0, 32'h3000, 1, 32'h3000, 8};

    reset = 1'b1;
    en    = 1'b1;
    drive(32'h0, 0, 2'b00, 0, 2'b00, 16'h0, 26'h0, 32'h0);

    // Reset state before any clock edge
    #3;
    chk("rst_pc", F_PC, 32'h3000);
    chk("rst_cnt", 32'(F_redirect_cnt), 32'h0);
    chk("rst_red", 32'(F_redirect), 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    chk("rst_mis", 32'(F_pc_misalign), 32'h0);
`endif
    tick();
    tick();
    reset = 1'b0;

    // Boot sequence
    #1;
    chk("boot_pc", F_PC, 32'h3000);
    tick();
    chk("run0_pc", F_PC, 32'h3000);
    tick();
    chk("run1_pc", F_PC, 32'h3004);
    tick();
    chk("run2_pc", F_PC, 32'h3008);

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].d_pc, vecs[i].d_equal, vecs[i].s_cmp, vecs[i].is_br, vecs[i].jump,
            vecs[i].imm16, vecs[i].imm26, vecs[i].rdata1);
      #1;
      chk($sformatf("vec%0d_red", i), 32'(F_redirect), 32'(vecs[i].exp_red));
      tick();
      chk($sformatf("vec%0d_pc", i), F_PC, vecs[i].exp_pc);
      chk($sformatf("vec%0d_cnt", i), 32'(F_redirect_cnt), vecs[i].exp_cnt);
    end

    // Stall for three cycles during a taken branch; target 0x3004 + 0x10
    drive(32'h3000, 1, 2'b00, 1, 2'b00, 16'h0004, 26'h0, 32'h0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall%0d_red", i), 32'(F_redirect), 32'h0);
      tick();
      chk($sformatf("stall%0d_pc", i), F_PC, 32'h3000);
    end
    en = 1'b1;
    #1;
    chk("hold_exit_red", 32'(F_redirect), 32'h0);
    tick();
    chk("hold_exit_pc", F_PC, 32'h3000);
    chk("resume_red", 32'(F_redirect), 32'h1);
    tick();
    chk("resume_pc", F_PC, 32'h3014);
    chk("resume_cnt", 32'(F_redirect_cnt), 32'd9);

    // Asynchronous reset mid-operation with a taken branch pending
    #2;
    reset = 1'b1;
    #1;
    chk("async_pc", F_PC, 32'h3000);
    chk("async_cnt", 32'(F_redirect_cnt), 32'h0);
    chk("async_red", 32'(F_redirect), 32'h0);
    reset = 1'b0;
    #1;
    chk("boot2_red", 32'(F_redirect), 32'h0);
    tick();
    chk("boot2_pc", F_PC, 32'h3000);
    chk("run_br_red", 32'(F_redirect), 32'h1);
    tick();
    chk("run_br_pc", F_PC, 32'h3014);

    // Counter wrap: jr back to 0x3000 until all-ones, then once more
    exp_cnt = 32'd1;
    drive(32'h0, 0, 2'b00, 0, 2'b10, 16'h0, 26'h0, 32'h3000);
    for (int i = 0; i < 15; i++) begin
      tick();
      exp_cnt = (exp_cnt + 32'd1) & 32'hF;
      chk($sformatf("wrap%0d_pc", i), F_PC, 32'h3000);
      chk($sformatf("wrap%0d_cnt", i), 32'(F_redirect_cnt), exp_cnt);
    end

`ifdef PC_ALIGN_CHECK_EN
    // Misaligned jr sets the flag; PC loads unmodified; aligned jr clears it
    drive(32'h0, 0, 2'b00, 0, 2'b10, 16'h0, 26'h0, 32'h3102);
    tick();
    chk("mis_pc", F_PC, 32'h3102);
    chk("mis_set", 32'(F_pc_misalign), 32'h1);
    drive(32'h0, 0, 2'b00, 0, 2'b00, 16'h0, 26'h0, 32'h0);
    en = 1'b0;
    tick();
    chk("mis_hold", 32'(F_pc_misalign), 32'h1);
    en = 1'b1;
    tick();
    drive(32'h0, 0, 2'b00, 0, 2'b10, 16'h0, 26'h0, 32'h3200);
    tick();
    chk("mis_clr_pc", F_PC, 32'h3200);
    chk("mis_clr", 32'(F_pc_misalign), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/f_pc_unit.md
F_PC_UNIT -- requirements
Module: F_PC_UNIT

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, the first fetch address after reset.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the redirect counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: from the stall unit; 0 freezes F and D.
REQ-006 SHALL have port D_PC, input, 32 bits: PC of the instruction currently in D.
REQ-007 SHALL have port D_equal, input, 1 bit: operand-equality result from the D-stage comparator.
REQ-008 SHALL have port s_D_cmp, input, 2 bits: branch kind; 2'b00 = BEQ, 2'b01 = BNE, others = never taken.
REQ-009 SHALL have port D_is_branch, input, 1 bit: the D instruction is a conditional branch.
REQ-010 SHALL have port D_jump, input, 2 bits: 2'b00 = none, 2'b01 = j/jal, 2'b10 = jr, 2'b11 = none.
REQ-011 SHALL have port D_imm16, input, 16 bits: branch offset.
REQ-012 SHALL have port D_imm26, input, 26 bits: jump index.
REQ-013 SHALL have port D_Rdata1, input, 32 bits: forwarded rs value, used by jr.
REQ-014 SHALL have port F_PC, output, 32 bits: current fetch address.
REQ-015 SHALL have port F_redirect, output, 1 bit: a redirect is applied at the next edge.
REQ-016 SHALL have port F_redirect_cnt, output, CNT_W bits: count of applied redirects.
REQ-017 SHALL have port F_pc_misalign, output, 1 bit: present only under the configuration macro (REQ-031).

Function
REQ-018 SHALL evaluate taken = D_is_branch & ((s_D_cmp==BEQ & D_equal) | (s_D_cmp==BNE & ~D_equal)), combinationally.
REQ-019 SHALL compute the branch target as D_PC + 4 + (sign-extended D_imm16 << 2), modulo 2^32.
REQ-020 SHALL compute the j/jal target as {D_PC[31:28], D_imm26, 2'b00}.
REQ-021 SHALL take the jr target as D_Rdata1 unmodified.
REQ-022 SHALL select NPC with priority jr > j/jal > taken branch > F_PC + 4; the delay slot is never flushed.
REQ-023 SHALL assert F_redirect = (state==RUN) & en & (taken | D_jump==01 | D_jump==10).
REQ-024 SHALL implement a three-state FSM: BOOT, RUN, HOLD.
- BOOT: F_PC = RESET_PC, no redirect; next state RUN, or HOLD if en=0.
- RUN: if en=1, load NPC; if en=0, go to HOLD and keep F_PC.
- HOLD: F_PC is held and F_redirect=0; the next state is RUN when en=1, with no NPC load in that cycle.
REQ-025 SHALL re-evaluate a branch after the HOLD→RUN transition; the decision is never latched while stalled.
REQ-026 SHALL have NPC latency of one edge: F_PC equals the selected target in the cycle after F_redirect=1.
REQ-027 SHALL increment F_redirect_cnt on each edge where F_redirect=1, wrapping to 0 past all-ones.
REQ-028 SHALL compute F_PC + 4 with wrap-around: 32'hFFFF_FFFC yields 32'h0000_0000.

Reset
REQ-029 SHALL, while reset=1 and independent of clk, force state=BOOT, F_PC=RESET_PC, F_redirect_cnt=0, F_redirect=0 and F_pc_misalign=0.
REQ-030 SHALL drop any in-progress branch or stall on reset asserted mid-operation; after release, the first edge leaves BOOT.

Configuration
REQ-031 SHALL provide macro PC_ALIGN_CHECK_EN.
- Defined: F_pc_misalign is registered, set on the edge that loads an NPC with bits [1:0]≠0, and cleared on the next load of an aligned value. The PC is still loaded unmodified.
- Undefined: the port is absent and no check logic exists.

Structure
REQ-032 SHALL place the s_D_cmp encodings (BEQ_CMP, BNE_CMP), the D_jump encodings, the FSM state encoding and the default RESET_PC in the shared pipeline package used by D_CMP and the controller.
REQ-033 SHALL use one sub-module, F_NPC, as pure combinational target/priority selection; the FSM, PC register and counter stay in F_PC_UNIT.

Verification
REQ-034 SHALL cover reset release with en=1: F_PC reads 0x3000 and 0x3000 in BOOT, then 0x3004 and 0x3008.
REQ-035 SHALL cover a taken BEQ: D_PC=0x3004, D_equal=1, s_D_cmp=00, D_imm16=0xFFFF → F_redirect=1, next F_PC=0x3004, cnt=1.
REQ-036 SHALL cover BNE with D_equal=1: no redirect, F_PC advances by +4.
REQ-037 SHALL cover jr and j asserted together with a taken branch: D_jump=10, D_Rdata1=0x3100 → next F_PC=0x3100 (jr wins).
REQ-038 SHALL cover en=0 for 3 cycles during a taken branch: F_PC held and F_redirect=0 throughout; the first RUN cycle after release redirects.
REQ-039 SHALL cover, with PC_ALIGN_CHECK_EN defined, jr to 0x3102 → F_pc_misalign=1, then the next aligned load clears it; also the counter wrap from all-ones to 0.
